// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 / AL422B frame FIFO write and read controllers.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package ov7670_pkg;

   localparam int DEF_H_PIX   = 320;
   localparam int DEF_V_LINES = 240;

   // RGB565 field widths; the first FIFO byte carries R and the top of G.
   localparam int R_W = 5;
   localparam int G_W = 6;
   localparam int B_W = 5;

   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb565_t;

   // Read/write sequencer state encoding (kept as plain constants so older
   // code that compares raw state vectors keeps working).
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RRST  = 3'd1;
   localparam logic [2:0] ST_PRIME = 3'd2;
   localparam logic [2:0] ST_RD_HI = 3'd3;
   localparam logic [2:0] ST_RD_LO = 3'd4;
   localparam logic [2:0] ST_PUSH  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   // Counter width for a count of n values; never returns 0.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ov7670_fifo_reader_if.sv
// Bundles the FIFO-read pins, the frame handshake and the pixel stream.
// Latency: n/a (wiring only).
// Backpressure: PIX_VALID/PIX_READY on the pixel stream.
// master = the reader; slave = FIFO, write controller and pixel sink side.
interface ov7670_fifo_reader_if;
   import ov7670_pkg::*;

   logic       WR_FRAME;
   logic       R_IDLE;
   logic       OV_RRST;
   logic       OV_OE;
   logic       OV_RCLK;
   logic [7:0] OV_DATA;
   rgb565_t    PIX_DATA;
   logic       PIX_VALID;
   logic       PIX_READY;
   logic       PIX_SOF;
   logic       PIX_EOL;
   logic       FRAME_DONE;

   modport master (
      input  WR_FRAME, OV_DATA, PIX_READY,
      output R_IDLE, OV_RRST, OV_OE, OV_RCLK,
      output PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, FRAME_DONE
   );

   modport slave (
      output WR_FRAME, OV_DATA, PIX_READY,
      input  R_IDLE, OV_RRST, OV_OE, OV_RCLK,
      input  PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, FRAME_DONE
   );

endinterface

// File: rtl/ov7670_rclk_gen.sv
// FIFO read-clock generator: OV_RCLK = SYS_CLK / (2*RCLK_HALF) while enabled.
// Latency: first rising edge RCLK_HALF cycles after en rises; strobe on the last cycle of each period.
// Backpressure: dropping en parks the clock low and restarts the half-period count.
// Ports: SYS_CLK/RST, en (run), rclk (OV_RCLK), rd_strobe (cycle in which rclk goes 1->0).
module ov7670_rclk_gen
   import ov7670_pkg::*;
#(
   parameter int RCLK_HALF = 2
) (
   input  logic SYS_CLK,
   input  logic RST,
   input  logic en,
   output logic rclk,
   output logic rd_strobe
);

   localparam int HW = cnt_w(RCLK_HALF);

   logic [HW-1:0] hcnt;
   logic          half_end;

   assign half_end  = en && (hcnt == HW'(RCLK_HALF - 1));
   // Falling edge of rclk: FIFO data launched on the rising edge is settled.
   assign rd_strobe = half_end && rclk;

   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         hcnt <= '0;
         rclk <= 1'b0;
      end else if (!en) begin
         hcnt <= '0;
         rclk <= 1'b0;
      end else if (half_end) begin
         hcnt <= '0;
         rclk <= ~rclk;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

endmodule

// File: rtl/ov7670_fifo_reader.sv
// AL422B read sequencer: on a WR_FRAME rise, resets the read pointer and streams H_PIX*V_LINES RGB565 pixels.
// Latency: RRST_CYCLES+1 read-clock periods to the first byte, then 4*RCLK_HALF+1 cycles per pixel.
// Backpressure: PIX_VALID holds with stable data while PIX_READY is low; OV_RCLK stays parked low.
// Ports: SYS_CLK, RST (async, active high), bus (ov7670_fifo_reader_if.master):
//   WR_FRAME in, R_IDLE out, OV_RRST/OV_OE/OV_RCLK out, OV_DATA in,
//   PIX_DATA/PIX_VALID/PIX_SOF/PIX_EOL out, PIX_READY in, FRAME_DONE out.
module ov7670_fifo_reader
   import ov7670_pkg::*;
#(
   parameter int H_PIX       = DEF_H_PIX,
   parameter int V_LINES     = DEF_V_LINES,
   parameter int RRST_CYCLES = 4,
   parameter int RCLK_HALF   = 2
) (
   input logic                        SYS_CLK,
   input logic                        RST,
   ov7670_fifo_reader_if.master       bus
);

   localparam int XW = cnt_w(H_PIX);
   localparam int YW = cnt_w(V_LINES);
   localparam int RW = cnt_w(RRST_CYCLES);

   logic [2:0]    state;
   logic          wr_frame_q;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [RW-1:0] rrst_cnt;

   logic          r_idle_q;
   logic          rrst_n_q;
   logic          oe_n_q;
   logic          vld_q;
   logic          done_q;
   rgb565_t       pix_q;

   logic          start;
   logic          x_last;
   logic          y_last;
   logic          rclk_en;
   logic          rclk;
   logic          rd_strobe;

   assign start   = bus.WR_FRAME && !wr_frame_q;
   assign x_last  = (x == XW'(H_PIX - 1));
   assign y_last  = (y == YW'(V_LINES - 1));
   // The read clock only runs while the FIFO pointer is meant to move.
   assign rclk_en = (state == ST_RRST) || (state == ST_PRIME) ||
                    (state == ST_RD_HI) || (state == ST_RD_LO);

   ov7670_rclk_gen #(
      .RCLK_HALF (RCLK_HALF)
   ) u_rclk_gen (
      .SYS_CLK   (SYS_CLK),
      .RST       (RST),
      .en        (rclk_en),
      .rclk      (rclk),
      .rd_strobe (rd_strobe)
   );

   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         wr_frame_q <= 1'b0;
         x          <= '0;
         y          <= '0;
         rrst_cnt   <= '0;
         r_idle_q   <= 1'b1;
         rrst_n_q   <= 1'b1;
         oe_n_q     <= 1'b1;
         vld_q      <= 1'b0;
         done_q     <= 1'b0;
         pix_q      <= '0;
      end else begin
         wr_frame_q <= bus.WR_FRAME;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RRST;
                  r_idle_q <= 1'b0;
                  rrst_n_q <= 1'b0;
               end
            end
            // Hold the read-pointer reset across whole read-clock periods.
            ST_RRST: begin
               if (rd_strobe) begin
                  if (rrst_cnt == RW'(RRST_CYCLES - 1)) begin
                     rrst_cnt <= '0;
                     rrst_n_q <= 1'b1;
                     oe_n_q   <= 1'b0;
                     state    <= ST_PRIME;
                  end else begin
                     rrst_cnt <= rrst_cnt + 1'b1;
                  end
               end
            end
            // One throw-away period covers the AL422B output pipeline.
            ST_PRIME: begin
               if (rd_strobe) begin
                  state <= ST_RD_HI;
               end
            end
            ST_RD_HI: begin
               if (rd_strobe) begin
                  pix_q[15:8] <= bus.OV_DATA;
                  state       <= ST_RD_LO;
               end
            end
            ST_RD_LO: begin
               if (rd_strobe) begin
                  pix_q[7:0] <= bus.OV_DATA;
                  vld_q      <= 1'b1;
                  state      <= ST_PUSH;
               end
            end
            // x/y only move on acceptance, so SOF/EOL stay stable with the data.
            ST_PUSH: begin
               if (bus.PIX_READY) begin
                  vld_q <= 1'b0;
                  if (x_last) begin
                     x <= '0;
                     if (y_last) begin
                        y      <= '0;
                        oe_n_q <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                     end else begin
                        y     <= y + 1'b1;
                        state <= ST_RD_HI;
                     end
                  end else begin
                     x     <= x + 1'b1;
                     state <= ST_RD_HI;
                  end
               end
            end
            ST_DONE: begin
               done_q   <= 1'b0;
               r_idle_q <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.R_IDLE     = r_idle_q;
   assign bus.OV_RRST    = rrst_n_q;
   assign bus.OV_OE      = oe_n_q;
   assign bus.OV_RCLK    = rclk;
   assign bus.PIX_DATA   = pix_q;
   assign bus.PIX_VALID  = vld_q;
   assign bus.PIX_SOF    = vld_q && (x == '0) && (y == '0);
   assign bus.PIX_EOL    = vld_q && x_last;
   assign bus.FRAME_DONE = done_q;

endmodule

// File: tb/tb_ov7670_fifo_reader.sv
module tb_ov7670_fifo_reader;
   import ov7670_pkg::*;

   logic SYS_CLK = 1'b0;
   logic RST;

   always #5 SYS_CLK = ~SYS_CLK;

   ov7670_fifo_reader_if ia ();
   ov7670_fifo_reader_if ib ();

   ov7670_fifo_reader #(
      .H_PIX(4), .V_LINES(2), .RRST_CYCLES(4), .RCLK_HALF(1)
   ) dut_a (
      .SYS_CLK (SYS_CLK),
      .RST     (RST),
      .bus     (ia)
   );

   ov7670_fifo_reader #(
      .H_PIX(16), .V_LINES(6), .RRST_CYCLES(4), .RCLK_HALF(2)
   ) dut_b (
      .SYS_CLK (SYS_CLK),
      .RST     (RST),
      .bus     (ib)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // FIFO models: pointer cleared while OV_RRST is low at a rising edge,
   // first byte after reset is a dummy, then 1,2,3,...
   int ka = 0;
   int kb = 0;
   int rise_a = 0;
   int rrst_rise_a = 0;

   always @(posedge ia.OV_RCLK) begin
      rise_a++;
      if (!ia.OV_RRST) begin
         rrst_rise_a++;
         ka = 0;
         ia.OV_DATA = 8'hEE;
      end else begin
         ia.OV_DATA = (ka == 0) ? 8'hEE : 8'(ka);
         ka++;
      end
   end

   always @(posedge ib.OV_RCLK) begin
      if (!ib.OV_RRST) begin
         kb = 0;
         ib.OV_DATA = 8'hEE;
      end else begin
         ib.OV_DATA = (kb == 0) ? 8'hEE : 8'(kb);
         kb++;
      end
   end

   int done_a = 0;
   always @(negedge SYS_CLK) begin
      if (ia.FRAME_DONE) done_a++;
   end

   // Second instance: random backpressure, streaming scoreboard.
   logic        b_rand = 1'b0;
   logic        b_mon_en = 1'b0;
   int          nb_acc = 0;
   int          nb_eol = 0;
   int          nb_sof = 0;
   int          nb_done = 0;
   logic        b_pend = 1'b0;
   logic [15:0] b_pd = '0;

   always @(posedge SYS_CLK) begin
      #1;
      ib.PIX_READY = b_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   always @(negedge SYS_CLK) begin
      if (b_mon_en) begin
         logic [15:0] e;
         if (b_pend) check("b_hold", {15'd0, ib.PIX_VALID, ib.PIX_DATA}, {15'd0, 1'b1, b_pd});
         b_pend = ib.PIX_VALID && !ib.PIX_READY;
         b_pd   = ib.PIX_DATA;
         if (ib.PIX_VALID && ib.PIX_READY) begin
            e = {8'(2 * nb_acc + 1), 8'(2 * nb_acc + 2)};
            check("b_pix", ib.PIX_DATA, e);
            check("b_eol", ib.PIX_EOL, (nb_acc % 16) == 15);
            nb_acc++;
            if (ib.PIX_EOL) nb_eol++;
            if (ib.PIX_SOF) nb_sof++;
         end
         if (ib.FRAME_DONE) nb_done++;
      end
   end

   typedef struct {
      int          stall;
      logic [15:0] data;
      logic        sof;
      logic        eol;
   } vec_t;

   vec_t vec [8];

   task automatic check_reset_a(input string tag);
      check({tag, "_r_idle"},  ia.R_IDLE, 1);
      check({tag, "_rrst"},    ia.OV_RRST, 1);
      check({tag, "_oe"},      ia.OV_OE, 1);
      check({tag, "_rclk"},    ia.OV_RCLK, 0);
      check({tag, "_valid"},   ia.PIX_VALID, 0);
      check({tag, "_data"},    ia.PIX_DATA, 0);
      check({tag, "_sof"},     ia.PIX_SOF, 0);
      check({tag, "_eol"},     ia.PIX_EOL, 0);
      check({tag, "_done"},    ia.FRAME_DONE, 0);
   endtask

   task automatic wait_valid_a(input string tag);
      int n = 0;
      do begin
         @(negedge SYS_CLK);
         n++;
      end while (!ia.PIX_VALID && n < 200);
      check({tag, "_valid_seen"}, ia.PIX_VALID, 1);
   endtask

   task automatic wait_done_a(input string tag);
      int n = 0;
      do begin
         @(negedge SYS_CLK);
         n++;
      end while (!ia.FRAME_DONE && n < 200);
      check({tag, "_done_seen"}, ia.FRAME_DONE, 1);
      check({tag, "_r_idle_at_done"}, ia.R_IDLE, 0);
      @(negedge SYS_CLK);
      check({tag, "_done_pulse_end"}, ia.FRAME_DONE, 0);
      check({tag, "_r_idle_after"}, ia.R_IDLE, 1);
   endtask

   // Applies the vector table to one frame of dut_a.
   task automatic run_vectors(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(posedge SYS_CLK);
         #1;
         ia.PIX_READY = (vec[i].stall == 0);
         wait_valid_a($sformatf("%s_px%0d", tag, i));
         check($sformatf("%s_px%0d_data", tag, i), ia.PIX_DATA, vec[i].data);
         check($sformatf("%s_px%0d_sof", tag, i), ia.PIX_SOF, vec[i].sof);
         check($sformatf("%s_px%0d_eol", tag, i), ia.PIX_EOL, vec[i].eol);
         check($sformatf("%s_px%0d_r_idle", tag, i), ia.R_IDLE, 0);
         if (vec[i].stall != 0) begin
            int rb = rise_a;
            for (int s = 0; s < vec[i].stall; s++) begin
               @(negedge SYS_CLK);
               check($sformatf("%s_stall%0d", tag, s), {ia.PIX_VALID, ia.PIX_DATA}, {1'b1, vec[i].data});
            end
            check({tag, "_stall_no_rclk"}, rise_a - rb, 0);
            check({tag, "_stall_rclk_low"}, ia.OV_RCLK, 0);
            @(posedge SYS_CLK);
            #1;
            ia.PIX_READY = 1'b1;
            @(negedge SYS_CLK);
            check({tag, "_resume_data"}, {ia.PIX_VALID, ia.PIX_DATA}, {1'b1, vec[i].data});
         end
      end
   endtask

   initial begin
      int rb;
      int rrb;
      int db;
      int n;

      for (int i = 0; i < 8; i++) begin
         vec[i].stall = (i == 2) ? 10 : 0;
         vec[i].data  = {8'(2 * i + 1), 8'(2 * i + 2)};
         vec[i].sof   = (i == 0);
         vec[i].eol   = (i == 3) || (i == 7);
      end

      RST = 1'b1;
      ia.WR_FRAME  = 1'b0;
      ib.WR_FRAME  = 1'b0;
      ia.PIX_READY = 1'b1;
      repeat (3) @(posedge SYS_CLK);
      #1;
      check_reset_a("rst");
      RST = 1'b0;
      repeat (2) @(posedge SYS_CLK);
      #1;

      // Frame 1: full frame, stall on pixel 2.
      rb = rise_a; rrb = rrst_rise_a; db = done_a;
      ia.WR_FRAME = 1'b1;
      @(posedge SYS_CLK);
      @(negedge SYS_CLK);
      check("f1_start_r_idle", ia.R_IDLE, 0);
      check("f1_start_rrst", ia.OV_RRST, 0);
      n = 0;
      while (ia.OV_OE && n < 200) begin
         @(negedge SYS_CLK);
         n++;
      end
      check("f1_oe_low", ia.OV_OE, 0);
      check("f1_rrst_released", ia.OV_RRST, 1);
      check("f1_rrst_periods", rrst_rise_a - rrb, 4);
      run_vectors("f1");
      wait_done_a("f1");
      check("f1_rclk_count", rise_a - rb, 21);
      check("f1_done_count", done_a - db, 1);
      check("f1_oe_off", ia.OV_OE, 1);

      // WR_FRAME still high: a level must not start another read.
      rb = rise_a;
      repeat (30) @(negedge SYS_CLK);
      check("lvl_r_idle", ia.R_IDLE, 1);
      check("lvl_no_rclk", rise_a - rb, 0);

      // Frame 2: fresh rise, plus a second rise during the read.
      @(posedge SYS_CLK);
      #1;
      ia.WR_FRAME = 1'b0;
      repeat (2) @(posedge SYS_CLK);
      #1;
      rb = rise_a; db = done_a;
      ia.WR_FRAME = 1'b1;
      repeat (8) @(posedge SYS_CLK);
      #1;
      ia.WR_FRAME = 1'b0;
      repeat (2) @(posedge SYS_CLK);
      #1;
      ia.WR_FRAME = 1'b1;
      run_vectors("f2");
      wait_done_a("f2");
      repeat (40) @(negedge SYS_CLK);
      check("f2_single_read_rclk", rise_a - rb, 21);
      check("f2_done_count", done_a - db, 1);
      check("f2_r_idle", ia.R_IDLE, 1);

      // Frame 3: reset during RD_LO of pixel 5, then restart.
      @(posedge SYS_CLK);
      #1;
      ia.WR_FRAME = 1'b0;
      ia.PIX_READY = 1'b1;
      repeat (2) @(posedge SYS_CLK);
      #1;
      rb = rise_a;
      ia.WR_FRAME = 1'b1;
      n = 0;
      while ((rise_a - rb) < 17 && n < 300) begin
         @(negedge SYS_CLK);
         n++;
      end
      check("f3_reached_px5", rise_a - rb, 17);
      check("f3_px5_hi_loaded", ia.PIX_DATA, 16'h0B0A);
      ia.WR_FRAME = 1'b0;
      RST = 1'b1;
      #1;
      check_reset_a("f3_async");
      @(posedge SYS_CLK);
      #1;
      RST = 1'b0;
      repeat (3) @(posedge SYS_CLK);
      #1;
      rb = rise_a; rrb = rrst_rise_a; db = done_a;
      ia.WR_FRAME = 1'b1;
      @(posedge SYS_CLK);
      @(negedge SYS_CLK);
      check("f3_restart_rrst", ia.OV_RRST, 0);
      run_vectors("f3");
      wait_done_a("f3");
      check("f3_rrst_periods", rrst_rise_a - rrb, 4);
      check("f3_rclk_count", rise_a - rb, 21);
      check("f3_done_count", done_a - db, 1);

      // Second instance: 16x6 frame, RCLK_HALF=2, random PIX_READY.
      b_rand   = 1'b1;
      b_mon_en = 1'b1;
      @(posedge SYS_CLK);
      #2;
      ib.WR_FRAME = 1'b1;
      n = 0;
      while (nb_done == 0 && n < 20000) begin
         @(negedge SYS_CLK);
         n++;
      end
      check("b_done_seen", nb_done, 1);
      repeat (20) @(negedge SYS_CLK);
      check("b_pixel_count", nb_acc, 96);
      check("b_eol_count", nb_eol, 6);
      check("b_sof_count", nb_sof, 1);
      check("b_done_count", nb_done, 1);
      check("b_r_idle", ib.R_IDLE, 1);
      check("b_oe_off", ib.OV_OE, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
